// File: rtl/writeback_queue_if.sv
// Result-write request channel into the writeback queue.
// Handshake: a transfer happens on any cycle where in_valid and in_ready are both 1.
interface writeback_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [31:0] in_data;

  modport master (output in_valid, output in_rd, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rd, input in_data, output in_ready);
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between execute/load and the register file, with pending-write
// scoreboard lookups. Define WBQ_BYPASS_EN to forward the youngest pending value instead of stalling.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  writeback_queue_if.slave           push,
  input  logic                       drain_en,
  output logic                       we,
  output logic [3:0]                 rd,
  output logic [31:0]                rd_data,
  input  logic [3:0]                 chk_rs1,
  input  logic [3:0]                 chk_rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic                       rs1_fwd_valid,
  output logic                       rs2_fwd_valid,
  output logic [31:0]                rs1_fwd_data,
  output logic [31:0]                rs2_fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_hit1;
  logic          w_hit2;

  // Acceptance looks only at occupancy so a full queue never relies on a same-cycle pop.
  assign push.in_ready = !rst && (r_count < CW'(DEPTH));
  assign w_push        = push.in_valid && push.in_ready && (push.in_rd != 4'd0);
  assign w_pop         = !rst && drain_en && (r_count != '0);

  assign we      = w_pop;
  assign rd      = w_pop ? r_rd[r_head]   : 4'd0;
  assign rd_data = w_pop ? r_data[r_head] : 32'd0;
  assign count   = r_count;

`ifdef WBQ_BYPASS_EN
  logic [31:0] w_data1;
  logic [31:0] w_data2;
`endif

  // Scan oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    logic [AW-1:0] idx;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
`ifdef WBQ_BYPASS_EN
    w_data1 = 32'd0;
    w_data2 = 32'd0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + AW'(k);
      if (!rst && (CW'(k) < r_count)) begin
        if ((chk_rs1 != 4'd0) && (r_rd[idx] == chk_rs1)) begin
          w_hit1 = 1'b1;
`ifdef WBQ_BYPASS_EN
          w_data1 = r_data[idx];
`endif
        end
        if ((chk_rs2 != 4'd0) && (r_rd[idx] == chk_rs2)) begin
          w_hit2 = 1'b1;
`ifdef WBQ_BYPASS_EN
          w_data2 = r_data[idx];
`endif
        end
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  assign rs1_busy      = 1'b0;
  assign rs2_busy      = 1'b0;
  assign rs1_fwd_valid = w_hit1;
  assign rs2_fwd_valid = w_hit2;
  assign rs1_fwd_data  = w_data1;
  assign rs2_fwd_data  = w_data2;
`else
  assign rs1_busy      = w_hit1;
  assign rs2_busy      = w_hit2;
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = 32'd0;
  assign rs2_fwd_data  = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= push.in_rd;
      r_data[r_tail] <= push.in_data;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4): ordering, full/empty, rd=0 drop, lookups, reset.
module tb_writeback_queue;

  logic        clk;
  logic        rst;
  logic        drain_en;
  logic        we;
  logic [3:0]  rd;
  logic [31:0] rd_data;
  logic [3:0]  chk_rs1;
  logic [3:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rs1_fwd_valid;
  logic        rs2_fwd_valid;
  logic [31:0] rs1_fwd_data;
  logic [31:0] rs2_fwd_data;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  logic [35:0] exp_q[$];

  writeback_queue_if bus ();

  writeback_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .push          (bus),
    .drain_en      (drain_en),
    .we            (we),
    .rd            (rd),
    .rd_data       (rd_data),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data),
    .count         (count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; expected outputs come from the reference queue exp_q.
  task automatic cycle(input bit v, input logic [3:0] r, input logic [31:0] d, input bit de);
    logic        exp_we;
    logic        accept;
    logic [35:0] front;
    bus.in_valid = v;
    bus.in_rd    = r;
    bus.in_data  = d;
    drain_en     = de;
    #1;
    accept = exp_q.size() < 4;
    check("in_ready", 32'(bus.in_ready), 32'(accept));
    check("count", 32'(count), 32'(exp_q.size()));
    exp_we = de && (exp_q.size() > 0);
    check("we", 32'(we), 32'(exp_we));
    if (exp_we) begin
      front = exp_q[0];
      check("rd", 32'(rd), 32'(front[35:32]));
      check("rd_data", rd_data, front[31:0]);
      void'(exp_q.pop_front());
    end else begin
      check("rd_idle", 32'(rd), 32'd0);
      check("rd_data_idle", rd_data, 32'd0);
    end
    if (v && accept && (r != 4'd0)) exp_q.push_back({r, d});
    step();
  endtask

  task automatic check_rs(input string tag, input logic [3:0] c1, input logic [3:0] c2,
                          input bit h1, input logic [31:0] d1,
                          input bit h2, input logic [31:0] d2);
    chk_rs1 = c1;
    chk_rs2 = c2;
    #1;
`ifdef WBQ_BYPASS_EN
    check({tag, "_rs1_busy"}, 32'(rs1_busy), 32'd0);
    check({tag, "_rs2_busy"}, 32'(rs2_busy), 32'd0);
    check({tag, "_rs1_fv"}, 32'(rs1_fwd_valid), 32'(h1));
    check({tag, "_rs2_fv"}, 32'(rs2_fwd_valid), 32'(h2));
    check({tag, "_rs1_fd"}, rs1_fwd_data, h1 ? d1 : 32'd0);
    check({tag, "_rs2_fd"}, rs2_fwd_data, h2 ? d2 : 32'd0);
`else
    check({tag, "_rs1_busy"}, 32'(rs1_busy), 32'(h1));
    check({tag, "_rs2_busy"}, 32'(rs2_busy), 32'(h2));
    check({tag, "_rs1_fv"}, 32'(rs1_fwd_valid), 32'd0);
    check({tag, "_rs2_fv"}, 32'(rs2_fwd_valid), 32'd0);
    check({tag, "_rs1_fd"}, rs1_fwd_data, 32'd0);
    check({tag, "_rs2_fd"}, rs2_fwd_data, 32'd0);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    drain_en     = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rd    = 4'd0;
    bus.in_data  = 32'd0;
    chk_rs1      = 4'd0;
    chk_rs2      = 4'd0;
    step();
    step();

    // reset holds every output low
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    drain_en = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);

    // lookups ignore the in_* side: an offered write is not yet pending
    bus.in_valid = 1'b1;
    bus.in_rd    = 4'd9;
    check_rs("empty_inflight", 4'd9, 4'd9, 1'b0, 32'd0, 1'b0, 32'd0);
    bus.in_valid = 1'b0;
    step();

    // single write with one-cycle latency
    cycle(1'b1, 4'd5, 32'hDEADBEEF, 1'b1);
    check("lat_we", 32'(we), 32'd1);
    check("lat_rd", 32'(rd), 32'd5);
    check("lat_data", rd_data, 32'hDEADBEEF);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);

    // rd=0 request is accepted but dropped
    cycle(1'b1, 4'd0, 32'h1234, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    check("rd0_count", 32'(count), 32'd0);

    // fill to DEPTH, refuse a 5th even with a same-cycle pop, then drain in order
    cycle(1'b1, 4'd1, 32'h1111_0001, 1'b0);
    cycle(1'b1, 4'd2, 32'h2222_0002, 1'b0);
    cycle(1'b1, 4'd3, 32'h3333_0003, 1'b0);
    cycle(1'b1, 4'd4, 32'h4444_0004, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, 4'd6, 32'h6666_0006, 1'b0);
    cycle(1'b1, 4'd7, 32'h7777_0007, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    check("drained_count", 32'(count), 32'd0);

    // same register pending twice: busy, or forward the younger value
    cycle(1'b1, 4'd3, 32'h0000_000A, 1'b0);
    cycle(1'b1, 4'd3, 32'h0000_000B, 1'b0);
    check_rs("dup", 4'd3, 4'd7, 1'b1, 32'h0000_000B, 1'b0, 32'd0);
    check_rs("rs0", 4'd0, 4'd3, 1'b0, 32'd0, 1'b1, 32'h0000_000B);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    drain_en = 1'b1;
    check_rs("head_wr", 4'd3, 4'd0, 1'b1, 32'h0000_000B, 1'b0, 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    check_rs("gone", 4'd3, 4'd3, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_rs1 = 4'd0;
    chk_rs2 = 4'd0;

    // steady push+pop at count=2 walks both pointers past DEPTH-1
    cycle(1'b1, 4'd8, 32'hA000_0008, 1'b0);
    cycle(1'b1, 4'd9, 32'hA000_0009, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'(10 + i), 32'hB000_0000 + 32'(i), 1'b1);
      check("stream_count", 32'(count), 32'd2);
    end
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);

    // reset mid-drain discards the remaining entries
    cycle(1'b1, 4'd1, 32'hC000_0001, 1'b0);
    cycle(1'b1, 4'd2, 32'hC000_0002, 1'b0);
    cycle(1'b1, 4'd3, 32'hC000_0003, 1'b0);
    cycle(1'b1, 4'd4, 32'hC000_0004, 1'b1);
    check("pre_rst_count", 32'(count), 32'd3);
    rst          = 1'b1;
    drain_en     = 1'b1;
    bus.in_valid = 1'b0;
    chk_rs1      = 4'd2;
    chk_rs2      = 4'd4;
    #1;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_rd", 32'(rd), 32'd0);
    check("mid_rst_data", rd_data, 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_busy1", 32'(rs1_busy), 32'd0);
    check("mid_rst_fv2", 32'(rs2_fwd_valid), 32'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("after_rst_count", 32'(count), 32'd0);
    check("after_rst_we", 32'(we), 32'd0);
    check("after_rst_ready", 32'(bus.in_ready), 32'd1);
    check_rs("after_rst", 4'd2, 4'd4, 1'b0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);

    // a few random-free directed pushes after reset confirm clean restart
    cycle(1'b1, 4'd15, 32'hFFFF_000F, 1'b1);
    cycle(1'b0, 4'd0, 32'd0, 1'b1);
    check("final_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
